// File: rtl/fifo_unpacker.sv
// Drains a show-ahead FIFO and splits each IN_WIDTH-bit word into RATIO narrower
// valid/ready beats, popping the next word in the same cycle the last beat leaves.
module fifo_unpacker #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] words_popped
);

    localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] hold;
    logic                hold_valid;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   sel;
    logic                last_beat;
    logic                xfer;
    logic                take;

    // With RATIO = 1 the beat index stays at 0, so every transfer is also a take.
    always_comb begin
        last_beat  = (beat == LAST_BEAT);
        xfer       = hold_valid & out_ready;
        take       = xfer & last_beat;
        fifo_rd_en = ~reset & ~fifo_empty & (~hold_valid | take);
        out_valid  = hold_valid;
        out_last   = hold_valid & last_beat;
        sel        = (MSB_FIRST != 0) ? (LAST_BEAT - beat) : beat;
        out_data   = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (sel == BEAT_W'(k)) begin
                out_data = hold[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold         <= '0;
            hold_valid   <= 1'b0;
            beat         <= '0;
            words_popped <= '0;
        end else if (fifo_rd_en) begin
            hold         <= fifo_dout;
            hold_valid   <= 1'b1;
            beat         <= '0;
            words_popped <= words_popped + CNT_WIDTH'(1);
        end else if (take) begin
            hold_valid   <= 1'b0;
            beat         <= '0;
        end else if (xfer) begin
            beat         <= beat + BEAT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: LSB-first, MSB-first (shared FIFO) and RATIO=1 instances,
// checked every cycle against a beat-queue reference model.
module tb_fifo_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic ready;
    logic ready_c;

    // Shared FIFO model for the LSB-first and MSB-first instances.
    logic [31:0] mem_ab [2048];
    int          wr_ab = 0;
    int          rd_ptr_ab = 0;
    logic        empty_ab;
    logic [31:0] dout_ab;
    assign empty_ab = (rd_ptr_ab == wr_ab);
    assign dout_ab  = mem_ab[rd_ptr_ab];

    logic [31:0] mem_c [64];
    int          wr_c = 0;
    int          rd_ptr_c = 0;
    logic        empty_c;
    logic [31:0] dout_c;
    assign empty_c = (rd_ptr_c == wr_c);
    assign dout_c  = mem_c[rd_ptr_c];

    logic        rd_a, rd_b, rd_c;
    logic [7:0]  data_a, data_b;
    logic [31:0] data_c;
    logic        valid_a, valid_b, valid_c;
    logic        last_a, last_b, last_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .fifo_dout(dout_ab), .fifo_empty(empty_ab),
        .fifo_rd_en(rd_a), .out_data(data_a), .out_valid(valid_a), .out_last(last_a),
        .out_ready(ready), .words_popped(cnt_a));

    fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .fifo_dout(dout_ab), .fifo_empty(empty_ab),
        .fifo_rd_en(rd_b), .out_data(data_b), .out_valid(valid_b), .out_last(last_b),
        .out_ready(ready), .words_popped(cnt_b));

    fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(32), .MSB_FIRST(0), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .fifo_dout(dout_c), .fifo_empty(empty_c),
        .fifo_rd_en(rd_c), .out_data(data_c), .out_valid(valid_c), .out_last(last_c),
        .out_ready(ready_c), .words_popped(cnt_c));

    always @(posedge clk) begin
        if (rd_a && rd_ptr_ab != wr_ab) rd_ptr_ab <= rd_ptr_ab + 1;
        if (rd_c && rd_ptr_c != wr_c) rd_ptr_c <= rd_ptr_c + 1;
    end

    // Reference model: beats still owed for the held word, and the expected beat stream.
    int          m_rem = 0;
    int          m_rd = 0;
    logic [15:0] m_cnt = '0;
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    int          mc_rem = 0;
    int          mc_rd = 0;
    logic [3:0]  mc_cnt = '0;
    logic [31:0] qc [$];

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  obs_a [$];
    logic [7:0]  obs_b [$];
    int          rd_pulses = 0;
    int          c_lasts = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data_a = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ab(input logic [31:0] w);
        mem_ab[wr_ab] = w;
        wr_ab++;
    endtask

    task automatic push_c(input logic [31:0] w);
        mem_c[wr_c] = w;
        wr_c++;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model.
    task automatic cycle();
        logic        ev, er, evc, erc;
        logic [31:0] w;
        #1;
        ev = (m_rem != 0);
        er = !reset && (m_rd != wr_ab) && (m_rem == 0 || (m_rem == 1 && ready));
        chk("valid_a", valid_a, ev);
        chk("valid_b", valid_b, ev);
        chk("rd_en_a", rd_a, er);
        chk("rd_en_b", rd_b, er);
        chk("last_a", last_a, ev && m_rem == 1);
        chk("last_b", last_b, ev && m_rem == 1);
        chk("words_a", cnt_a, m_cnt);
        chk("words_b", cnt_b, m_cnt);
        if (ev) begin
            chk("data_a", data_a, qa[0]);
            chk("data_b", data_b, qb[0]);
        end
        chk("pop_while_empty", rd_a && empty_ab, 1'b0);
        if (prev_stall && valid_a) chk("stall_hold_a", data_a, prev_data_a);

        evc = (mc_rem != 0);
        erc = !reset && (mc_rd != wr_c) && (mc_rem == 0 || ready_c);
        chk("valid_c", valid_c, evc);
        chk("rd_en_c", rd_c, erc);
        chk("last_c", last_c, evc);
        chk("words_c", cnt_c, mc_cnt);
        if (evc) chk("data_c", data_c, qc[0]);

        if (valid_a && ready) begin
            obs_a.push_back(data_a);
            obs_b.push_back(data_b);
        end
        if (rd_a) rd_pulses++;
        if (valid_c && ready_c && last_c) c_lasts++;
        prev_stall  = valid_a && !ready && !reset;
        prev_data_a = data_a;

        if (reset) begin
            m_rem = 0; qa.delete(); qb.delete(); m_cnt = '0;
            mc_rem = 0; qc.delete(); mc_cnt = '0;
        end else begin
            if (ev && ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                m_rem--;
            end
            if (er) begin
                w = mem_ab[m_rd];
                m_rd++;
                m_cnt++;
                m_rem = 4;
                for (int k = 0; k < 4; k++) begin
                    qa.push_back(w[8*k +: 8]);
                    qb.push_back(w[8*(3-k) +: 8]);
                end
            end
            if (evc && ready_c) begin
                void'(qc.pop_front());
                mc_rem = 0;
            end
            if (erc) begin
                qc.push_back(mem_c[mc_rd]);
                mc_rd++;
                mc_cnt++;
                mc_rem = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_lsb [8];
        logic [7:0] exp_msb [8];
        int         guard;
        exp_lsb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_msb = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

        reset = 1'b1; ready = 1'b0; ready_c = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", valid_a, 1'b0);
        chk("reset_last", last_a, 1'b0);
        chk("reset_data", data_a, 8'h00);
        chk("reset_rd_en", rd_a, 1'b0);
        chk("reset_words", cnt_a, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two preloaded words streamed at full rate.
        push_ab(32'h44332211);
        push_ab(32'h88776655);
        ready = 1'b1;
        repeat (12) cycle();
        chk("burst_beats", obs_a.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("burst_lsb_order", obs_a[i], exp_lsb[i]);
            chk("burst_msb_order", obs_b[i], exp_msb[i]);
        end
        chk("burst_pops", rd_pulses, 2);
        chk("burst_words", cnt_a, 16'd2);

        // FIFO runs dry, second word arrives five cycles later.
        push_ab(32'hA1B2C3D4);
        repeat (6) cycle();
        repeat (5) cycle();
        push_ab(32'h0F1E2D3C);
        repeat (6) cycle();

        // Reset while beat 2 of 0xDEADBEEF is presented.
        push_ab(32'hDEADBEEF);
        repeat (3) cycle();
        chk("pre_reset_beat", data_a, 8'hAD);
        reset = 1'b1; ready = 1'b0;
        cycle();
        reset = 1'b0; ready = 1'b1;
        chk("post_reset_data", data_a, 8'h00);
        chk("post_reset_words", cnt_a, 16'd0);
        obs_a.delete();
        repeat (5) cycle();
        chk("post_reset_no_beats", obs_a.size(), 0);

        // Random backpressure and arrivals over 1000 words.
        guard = 0;
        for (int pushed = 0; pushed < 1000 || m_rem != 0 || m_rd != wr_ab; ) begin
            ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push_ab($urandom);
                pushed++;
            end
            cycle();
            guard++;
            if (guard > 20000) begin
                chk("random_drain_timeout", guard, 20000);
                break;
            end
        end
        chk("random_words", cnt_a, 16'(1000));

        // RATIO = 1 instance: 20 back-to-back words, 4-bit counter wraps.
        ready = 1'b1;
        for (int i = 0; i < 20; i++) push_c($urandom);
        repeat (25) cycle();
        chk("ratio1_lasts", c_lasts, 20);
        chk("ratio1_words_wrap", cnt_c, 4'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
